// File: rtl/ym3438_pkg.sv
// ----------------------------------------------------------------------------
// ym3438_pkg
//   Shared constants for the OPN2 interval timers.
//   TIMER_A_* : 10-bit timer, no prescale.
//   TIMER_B_* : 8-bit timer, counts once every 16 sample ticks.
//   pre_width(): width of the prescale counter (at least 1 bit).
// ----------------------------------------------------------------------------
package ym3438_pkg;

    localparam int unsigned TIMER_A_WIDTH    = 10;
    localparam int unsigned TIMER_B_WIDTH    = 8;
    localparam int unsigned TIMER_A_PRESCALE = 1;
    localparam int unsigned TIMER_B_PRESCALE = 16;

    function automatic int unsigned pre_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/ym3438_timer_prescaler.sv
// ----------------------------------------------------------------------------
// ym3438_timer_prescaler
//   Divides the sample-rate tick by PRESCALE to produce the counter step strobe.
//   With PRESCALE=1 the divider is removed and step follows tick directly.
// Ports
//   MCLK   in   master clock
//   reset  in   synchronous active-high reset
//   tick   in   one-cycle sample-rate strobe
//   run    in   timer running (LOAD bit); low holds the divider at zero
//   clear  in   restart the divider (timer start cycle); also blocks step
//   step   out  one-cycle counter step strobe
// ----------------------------------------------------------------------------
module ym3438_timer_prescaler
    import ym3438_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic MCLK,
    input  logic reset,
    input  logic tick,
    input  logic run,
    input  logic clear,
    output logic step
);

    localparam int unsigned PW = pre_width(PRESCALE);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // Divider absent; the caller gates step with run/start itself.
            logic unused_inputs;
            assign unused_inputs = ^{MCLK, reset, run, clear};
            assign step          = tick;
        end else begin : g_div
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pre_q;
            logic [PW-1:0] pre_d;
            logic          wrap;

            assign wrap = (pre_q == PRE_LAST);

            always_comb begin
                pre_d = pre_q;
                if (!run || clear) begin
                    pre_d = '0;
                end else if (tick) begin
                    pre_d = wrap ? '0 : pre_q + 1'b1;
                end
            end

            always_ff @(posedge MCLK) begin
                if (reset) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end

            assign step = run && !clear && tick && wrap;
        end
    endgenerate

endmodule

// File: rtl/ym3438_timer_gen.sv
// ----------------------------------------------------------------------------
// ym3438_timer_gen
//   Generic OPN2 interval timer (one instance per timer A / timer B).
//   Counts prescaled sample ticks up to all-ones, reloads from load_val on
//   overflow, emits a one-cycle ovf pulse and sets a sticky flag.
// Parameters
//   WIDTH     counter width (1..16)
//   PRESCALE  ticks per count step (1..256)
// Ports
//   MCLK      in   master clock
//   reset     in   synchronous active-high reset
//   tick      in   one-cycle sample-rate strobe
//   load_val  in   reload value
//   load      in   run level; rising edge loads the counter
//   flag_en   in   overflow may set flag
//   flag_clr  in   one-cycle flag clear
//   count     out  current counter value
//   flag      out  sticky overflow flag
//   ovf       out  one-cycle overflow pulse
//   csm_mode  in   CSM enabled                (only with TIMER_CSM_EN)
//   csm_key   out  CSM key-on pulse with ovf  (only with TIMER_CSM_EN)
// Build option: define TIMER_CSM_EN to add the CSM key-on output.
// ----------------------------------------------------------------------------
module ym3438_timer_gen
    import ym3438_pkg::*;
#(
    parameter int unsigned WIDTH    = TIMER_A_WIDTH,
    parameter int unsigned PRESCALE = TIMER_A_PRESCALE
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load,
    input  logic             flag_en,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             flag,
    output logic             ovf
`ifdef TIMER_CSM_EN
    ,
    input  logic             csm_mode,
    output logic             csm_key
`endif
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             ovf_q, ovf_d;
    logic             load_d_q;
    logic             start;
    logic             step;
    logic             do_step;
    logic             wrap;

    // Start cycle: counter is (re)loaded and any tick in this cycle is dropped.
    assign start   = load && !load_d_q;
    assign do_step = step && load && !start;
    assign wrap    = (count_q == {WIDTH{1'b1}});

    ym3438_timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .MCLK  (MCLK),
        .reset (reset),
        .tick  (tick),
        .run   (load),
        .clear (start),
        .step  (step)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        flag_d  = flag_q;
        if (start) begin
            count_d = load_val;
        end else if (do_step) begin
            if (wrap) begin
                count_d = load_val;
                ovf_d   = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        // Set has priority over a coincident clear.
        if (flag_clr) begin
            flag_d = 1'b0;
        end
        if (ovf_d && flag_en) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            count_q  <= '0;
            flag_q   <= 1'b0;
            ovf_q    <= 1'b0;
            load_d_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
            load_d_q <= load;
        end
    end

`ifdef TIMER_CSM_EN
    logic csm_key_q;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            csm_key_q <= 1'b0;
        end else begin
            csm_key_q <= ovf_d && csm_mode;
        end
    end

    assign csm_key = csm_key_q;
`endif

    assign count = count_q;
    assign flag  = flag_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_ym3438_timer_gen.sv
// ----------------------------------------------------------------------------
// tb_ym3438_timer_gen
//   Self-checking bench: timer A (10-bit, no prescale) and timer B (8-bit, /16).
//   Expected outputs are queued as stimulus is applied and compared after the
//   clock edge. Build with TIMER_CSM_EN defined to also check csm_key.
// ----------------------------------------------------------------------------
module tb_ym3438_timer_gen;
    import ym3438_pkg::*;

    typedef struct packed {
        logic [9:0] count;
        logic       ovf;
        logic       flag;
        logic       csm;
    } exp_t;

    typedef struct packed {
        logic ld;
        logic tk;
        logic ovf;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Timer A
    logic       rst_a, tick_a, load_a, fen_a, fclr_a;
    logic [9:0] lv_a, cnt_a;
    logic       flag_a, ovf_a;
    // Timer B
    logic       rst_b, tick_b, load_b, fen_b, fclr_b;
    logic [7:0] lv_b, cnt_b;
    logic       flag_b, ovf_b;

    logic csm_m = 1'b0;

`ifdef TIMER_CSM_EN
    logic csm_mode_a, csm_key_a, csm_mode_b, csm_key_b;
    assign csm_mode_a = csm_m;
    assign csm_mode_b = 1'b0;
`endif

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ym3438_timer_gen #(
        .WIDTH    (TIMER_A_WIDTH),
        .PRESCALE (TIMER_A_PRESCALE)
    ) dut_a (
        .MCLK     (clk),
        .reset    (rst_a),
        .tick     (tick_a),
        .load_val (lv_a),
        .load     (load_a),
        .flag_en  (fen_a),
        .flag_clr (fclr_a),
        .count    (cnt_a),
        .flag     (flag_a),
        .ovf      (ovf_a)
`ifdef TIMER_CSM_EN
        ,
        .csm_mode (csm_mode_a),
        .csm_key  (csm_key_a)
`endif
    );

    ym3438_timer_gen #(
        .WIDTH    (TIMER_B_WIDTH),
        .PRESCALE (TIMER_B_PRESCALE)
    ) dut_b (
        .MCLK     (clk),
        .reset    (rst_b),
        .tick     (tick_b),
        .load_val (lv_b),
        .load     (load_b),
        .flag_en  (fen_b),
        .flag_clr (fclr_b),
        .count    (cnt_b),
        .flag     (flag_b),
        .ovf      (ovf_b)
`ifdef TIMER_CSM_EN
        ,
        .csm_mode (csm_mode_b),
        .csm_key  (csm_key_b)
`endif
    );

    function automatic exp_t obs_a();
        exp_t v;
        v.count = cnt_a;
        v.ovf   = ovf_a;
        v.flag  = flag_a;
`ifdef TIMER_CSM_EN
        v.csm   = csm_key_a;
`else
        v.csm   = 1'b0;
`endif
        return v;
    endfunction

    function automatic exp_t obs_b();
        exp_t v;
        v.count = {2'b00, cnt_b};
        v.ovf   = ovf_b;
        v.flag  = flag_b;
`ifdef TIMER_CSM_EN
        v.csm   = csm_key_b;
`else
        v.csm   = 1'b0;
`endif
        return v;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("cnt=%0d ovf=%b flag=%b csm=%b", v.count, v.ovf, v.flag, v.csm);
    endfunction

    task automatic clk_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb_a.push_back('{count: 10'd0, ovf: 1'b0, flag: 1'b0, csm: 1'b0});
            sb_b.push_back('{count: 10'd0, ovf: 1'b0, flag: 1'b0, csm: 1'b0});
            clk_cycle();
            e = sb_a.pop_front(); g = obs_a(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL reset_a[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
            e = sb_b.pop_front(); g = obs_b(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL reset_b[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    // load_val=1020: start, then 4 ticks wrap through all-ones back to 1020.
    task automatic test_basic();
        bit          ld[7] = '{0, 1, 1, 1, 1, 1, 1};
        bit          tk[7] = '{0, 0, 1, 1, 1, 1, 0};
        int unsigned ec[7] = '{0, 1020, 1021, 1022, 1023, 1020, 1020};
        bit          eo[7] = '{0, 0, 0, 0, 0, 1, 0};
        exp_t e, g;
        lv_a = 10'd1020; fen_a = 1'b0; fclr_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            load_a = ld[i]; tick_a = tk[i];
            sb_a.push_back('{count: 10'(ec[i]), ovf: eo[i], flag: 1'b0, csm: eo[i] & csm_m});
            clk_cycle();
            e = sb_a.pop_front(); g = obs_a(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL basic[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    // Set beats coincident clear; flag_en=0 never clears the flag.
    task automatic test_flag();
        bit          tk[12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 0};
        bit          fe[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        bit          fc[12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        int unsigned ec[12] = '{1021, 1022, 1023, 1020, 1020, 1021, 1022, 1023, 1020, 1020,
                                1021, 1021};
        bit          eo[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        bit          ef[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0};
        exp_t e, g;
        load_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick_a = tk[i]; fen_a = fe[i]; fclr_a = fc[i];
            sb_a.push_back('{count: 10'(ec[i]), ovf: eo[i], flag: ef[i], csm: eo[i] & csm_m});
            clk_cycle();
            e = sb_a.pop_front(); g = obs_a(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL flag[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        fen_a = 1'b0; fclr_a = 1'b0;
    endtask

    // Tick on the load rising edge is ignored; load=0 holds the count.
    task automatic test_start_tick();
        bit          ld[5] = '{0, 1, 1, 0, 0};
        bit          tk[5] = '{1, 1, 1, 1, 0};
        int unsigned ec[5] = '{1021, 500, 501, 501, 501};
        exp_t e, g;
        lv_a = 10'd500;
        for (int i = 0; i < 5; i++) begin
            load_a = ld[i]; tick_a = tk[i];
            sb_a.push_back('{count: 10'(ec[i]), ovf: 1'b0, flag: 1'b0, csm: 1'b0});
            clk_cycle();
            e = sb_a.pop_front(); g = obs_a(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL start_tick[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    // load_val 100 -> 200 mid-run: current run continues, reload uses 200.
    task automatic test_reload();
        exp_t        e, g;
        int unsigned cur;
        bit          wr;
        fen_a = 1'b0; lv_a = 10'd100;
        load_a = 1'b1; tick_a = 1'b0;
        sb_a.push_back('{count: 10'd100, ovf: 1'b0, flag: 1'b0, csm: 1'b0});
        clk_cycle();
        e = sb_a.pop_front(); g = obs_a(); n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL reload_start: got %s, want %s", fmt(g), fmt(e));
        end
        cur = 100;
        for (int i = 0; i < 925; i++) begin
            if (i == 400) lv_a = 10'd200;
            tick_a = 1'b1;
            wr  = (cur == 1023);
            cur = wr ? 32'(lv_a) : cur + 1;
            sb_a.push_back('{count: 10'(cur), ovf: wr, flag: 1'b0, csm: wr & csm_m});
            clk_cycle();
            e = sb_a.pop_front(); g = obs_a(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL reload[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        tick_a = 1'b0;
    endtask

    // csm_key follows ovf regardless of flag_en; reset mid-run drops everything.
    task automatic test_csm_reset();
        bit          rs[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        bit          ld[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        bit          tk[10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        bit          fe[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int unsigned ec[10] = '{201, 1022, 1023, 1022, 1023, 0, 1022, 1023, 1022, 1022};
        bit          eo[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit          ef[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        exp_t e, g;
`ifdef TIMER_CSM_EN
        csm_m = 1'b1;
`endif
        lv_a = 10'd1022;
        for (int i = 0; i < 10; i++) begin
            rst_a = rs[i]; load_a = ld[i]; tick_a = tk[i]; fen_a = fe[i];
            sb_a.push_back('{count: 10'(ec[i]), ovf: eo[i], flag: ef[i], csm: eo[i] & csm_m});
            clk_cycle();
            e = sb_a.pop_front(); g = obs_a(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL csm_reset[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        rst_a = 1'b0; tick_a = 1'b0;
    endtask

    // Timer B, load_val=255: one overflow per 16 ticks; load=0 restarts the divider.
    task automatic test_prescale();
        stim_t st[$];
        exp_t  e, g;
        bit    fl;
        lv_b = 8'd255; fen_b = 1'b1; fclr_b = 1'b0;
        st.push_back('{ld: 1'b0, tk: 1'b0, ovf: 1'b0});
        st.push_back('{ld: 1'b1, tk: 1'b0, ovf: 1'b0});
        for (int i = 0; i < 32; i++) st.push_back('{ld: 1'b1, tk: 1'b1, ovf: (i == 15 || i == 31)});
        for (int i = 0; i < 32; i++) st.push_back('{ld: 1'b1, tk: i[0], ovf: (i == 31)});
        for (int i = 0; i < 15; i++) st.push_back('{ld: 1'b1, tk: 1'b1, ovf: 1'b0});
        st.push_back('{ld: 1'b0, tk: 1'b1, ovf: 1'b0});
        st.push_back('{ld: 1'b1, tk: 1'b1, ovf: 1'b0});
        for (int i = 0; i < 16; i++) st.push_back('{ld: 1'b1, tk: 1'b1, ovf: (i == 15)});
        fl = 1'b0;
        for (int i = 0; i < st.size(); i++) begin
            load_b = st[i].ld; tick_b = st[i].tk;
            fl = fl | st[i].ovf;
            sb_b.push_back('{count: (i == 0) ? 10'd0 : 10'd255, ovf: st[i].ovf, flag: fl,
                             csm: 1'b0});
            clk_cycle();
            e = sb_b.pop_front(); g = obs_b(); n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL prescale[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        tick_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; tick_a = 1'b0; load_a = 1'b0; fen_a = 1'b0; fclr_a = 1'b0; lv_a = '0;
        rst_b = 1'b1; tick_b = 1'b0; load_b = 1'b0; fen_b = 1'b0; fclr_b = 1'b0; lv_b = '0;
        test_reset();
        test_basic();
        test_flag();
        test_start_tick();
        test_reload();
        test_csm_reset();
        test_prescale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
